// File: rtl/display_pkg.sv
// Shared types and 7-segment encodings for the decimal display driver.
// Segment codes are active-low, packed g..a (bit 6 = g, bit 0 = a).
package display_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ATUALIZA = 2'd2
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to active-low 7-segment code; dash overrides blank,
// blank overrides the digit.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  input  logic       i_dash,
  output logic [6:0] o_seg
);

  always_comb begin
    if (i_dash)
      o_seg = SEG_DASH;
    else if (i_blank)
      o_seg = SEG_BLANK;
    else
      o_seg = seg_code(i_bcd);
  end

endmodule

// File: rtl/display_decimal.sv
// Decimal display driver: sequential double-dabble conversion of a loaded
// binary value, then a single-cycle update of all active-low digit outputs.
module display_decimal
  import display_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      valor,
  input  logic                  carregar,
  input  logic                  apagar_zeros,
  output logic                  ocupado,
  output logic                  pronto,
  output logic [7*DIGITS-1:0]   hex
);

  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++)
      p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX = pow10_minus1(DIGITS);
  localparam int          CW  = $clog2(WIDTH + 1);
  localparam int          BW  = 4 * DIGITS;

  state_t              r_state;
  state_t              w_next;
  logic [WIDTH-1:0]    r_bin;
  logic [BW-1:0]       r_bcd;
  logic [BW-1:0]       w_bcd_adj;
  logic [CW-1:0]       r_cnt;
  logic                r_blank_en;
  logic                r_ovf;
  logic                r_pronto;
  logic [7*DIGITS-1:0] r_hex;
  logic [7*DIGITS-1:0] w_seg;
  logic [DIGITS-1:0]   w_dig_blank;
  logic                w_load;
  logic                w_shift;
  logic                w_update;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= OCIOSO;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      OCIOSO:   if (carregar) w_next = CONVERTE;
      CONVERTE: if (r_cnt == CW'(1)) w_next = ATUALIZA;
      ATUALIZA: w_next = OCIOSO;
      default:  w_next = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado  = (r_state != OCIOSO);
    w_load   = (r_state == OCIOSO) && carregar;
    w_shift  = (r_state == CONVERTE);
    w_update = (r_state == ATUALIZA);
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5)
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // A one shifted out of the top nibble also means the value needs more
  // digits than we have, so it folds into the overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_blank_en <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_load) begin
      r_bin      <= valor;
      r_bcd      <= '0;
      r_cnt      <= CW'(WIDTH);
      r_blank_en <= apagar_zeros;
      r_ovf      <= (64'(valor) > MAX);
    end else if (w_shift) begin
      r_bcd <= {w_bcd_adj[BW-2:0], r_bin[WIDTH-1]};
      r_bin <= {r_bin[WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt - CW'(1);
      r_ovf <= r_ovf | w_bcd_adj[BW-1];
    end
  end

  // Walk down from the top digit; a digit is blanked while every digit
  // above it (and itself) is zero. Digit 0 always shows.
  always_comb begin
    logic v_run;
    v_run       = 1'b1;
    w_dig_blank = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      v_run          = v_run & (r_bcd[4*k +: 4] == 4'd0);
      w_dig_blank[k] = r_blank_en & v_run;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    seg7_decoder u_dec (
      .i_bcd   (r_bcd[4*k +: 4]),
      .i_blank (w_dig_blank[k]),
      .i_dash  (r_ovf),
      .o_seg   (w_seg[7*k +: 7])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex    <= {DIGITS{SEG_BLANK}};
      r_pronto <= 1'b0;
    end else begin
      r_pronto <= w_update;
      if (w_update)
        r_hex <= w_seg;
    end
  end

  assign hex    = r_hex;
  assign pronto = r_pronto;

endmodule

// File: tb/tb_display_decimal.sv
// Directed bench for display_decimal: default 16-bit/4-digit instance and
// an 8-bit/2-digit instance, table-driven conversions plus corner sequences.
module tb_display_decimal;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] valor;
  logic        carregar;
  logic        apagar_zeros;
  logic        ocupado;
  logic        pronto;
  logic [27:0] hex;
  logic [7:0]  s_valor;
  logic        s_carregar;
  logic        s_apagar;
  logic        s_ocupado;
  logic        s_pronto;
  logic [13:0] s_hex;

  always #5 clk = ~clk;

  display_decimal #(.WIDTH(16), .DIGITS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .valor(valor), .carregar(carregar),
    .apagar_zeros(apagar_zeros), .ocupado(ocupado), .pronto(pronto), .hex(hex)
  );

  display_decimal #(.WIDTH(8), .DIGITS(2)) u_small (
    .clk(clk), .rst_n(rst_n), .valor(s_valor), .carregar(s_carregar),
    .apagar_zeros(s_apagar), .ocupado(s_ocupado), .pronto(s_pronto), .hex(s_hex)
  );

  typedef struct {
    int          v;
    bit          bz;
    logic [27:0] exp;
    string       name;
  } vec_t;

  vec_t big_tbl[11];
  vec_t small_tbl[5];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] cur_hex(input bit sel);
    return sel ? {14'd0, s_hex} : hex;
  endfunction

  function automatic logic cur_pronto(input bit sel);
    return sel ? s_pronto : pronto;
  endfunction

  function automatic logic cur_ocup(input bit sel);
    return sel ? s_ocupado : ocupado;
  endfunction

  task automatic drive(input bit sel, input bit c, input int v, input bit bz);
    if (sel) begin
      s_carregar = c; s_valor = v[7:0]; s_apagar = bz;
    end else begin
      carregar = c; valor = v[15:0]; apagar_zeros = bz;
    end
  endtask

  // k counts negedges after the accepting edge T0; pronto is due at k = W+2.
  task automatic conv(input bit sel, input int v, input bit bz, input int inject,
                      output logic [27:0] hx, output int first_k, output int npr,
                      output bit stable, output bit ocup_ok);
    int w;
    logic [27:0] prev;
    w = sel ? 8 : 16;
    @(negedge clk);
    prev    = cur_hex(sel);
    hx      = prev;
    first_k = -1;
    npr     = 0;
    stable  = 1'b1;
    ocup_ok = 1'b1;
    drive(sel, 1'b1, v, bz);
    for (int k = 1; k <= w + 5; k++) begin
      @(negedge clk);
      if (cur_pronto(sel)) begin
        npr++;
        if (first_k < 0) begin
          first_k = k;
          hx      = cur_hex(sel);
          if (cur_ocup(sel)) ocup_ok = 1'b0;
        end
      end else if (first_k < 0) begin
        if (cur_hex(sel) !== prev) stable = 1'b0;
        if (!cur_ocup(sel) && k <= w + 1) ocup_ok = 1'b0;
      end
      if (k == 1) drive(sel, 1'b0, 0, 1'b0);
      if (inject > 0 && k == inject) drive(sel, 1'b1, 55, 1'b0);
      if (inject > 0 && k == inject + 1) drive(sel, 1'b0, 0, 1'b0);
    end
  endtask

  task automatic run_vec(input bit sel, input vec_t t, input int inject);
    logic [27:0] hx;
    int first_k, npr;
    bit stable, ocup_ok;
    int w;
    w = sel ? 8 : 16;
    conv(sel, t.v, t.bz, inject, hx, first_k, npr, stable, ocup_ok);
    chk($sformatf("%s_latency", t.name), 64'(first_k), 64'(w + 2));
    chk($sformatf("%s_pronto_count", t.name), 64'(npr), 64'd1);
    chk($sformatf("%s_hex", t.name), 64'(hx), 64'(t.exp));
    chk($sformatf("%s_hex_held", t.name), 64'(stable), 64'd1);
    chk($sformatf("%s_ocupado", t.name), 64'(ocup_ok), 64'd1);
  endtask

  initial begin
    int npr;
    vec_t t;

    big_tbl[0]  = '{1234,  1'b0, {S1, S2, S3, S4}, "b1234"};
    big_tbl[1]  = '{9999,  1'b0, {S9, S9, S9, S9}, "b9999"};
    big_tbl[2]  = '{10000, 1'b0, {SD, SD, SD, SD}, "b10000"};
    big_tbl[3]  = '{5,     1'b1, {SB, SB, SB, S5}, "b5_blank"};
    big_tbl[4]  = '{0,     1'b1, {SB, SB, SB, S0}, "b0_blank"};
    big_tbl[5]  = '{0,     1'b0, {S0, S0, S0, S0}, "b0_noblank"};
    big_tbl[6]  = '{65535, 1'b0, {SD, SD, SD, SD}, "b65535"};
    big_tbl[7]  = '{1000,  1'b1, {S1, S0, S0, S0}, "b1000_blank"};
    big_tbl[8]  = '{40,    1'b1, {SB, SB, S4, S0}, "b40_blank"};
    big_tbl[9]  = '{9,     1'b0, {S0, S0, S0, S9}, "b9_noblank"};
    big_tbl[10] = '{10000, 1'b1, {SD, SD, SD, SD}, "b10000_blank"};

    small_tbl[0] = '{255, 1'b0, {14'd0, SD, SD}, "s255"};
    small_tbl[1] = '{99,  1'b0, {14'd0, S9, S9}, "s99"};
    small_tbl[2] = '{7,   1'b1, {14'd0, SB, S7}, "s7_blank"};
    small_tbl[3] = '{100, 1'b1, {14'd0, SD, SD}, "s100_blank"};
    small_tbl[4] = '{10,  1'b1, {14'd0, S1, S0}, "s10_blank"};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_hex", 64'(hex), 64'({SB, SB, SB, SB}));
    chk("reset_ocupado", 64'(ocupado), 64'd0);
    chk("reset_pronto", 64'(pronto), 64'd0);
    chk("reset_small_hex", 64'(s_hex), 64'({SB, SB}));
    rst_n = 1'b1;

    npr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pronto) npr++;
    end
    chk("idle_no_pronto", 64'(npr), 64'd0);
    chk("idle_hex_blank", 64'(hex), 64'({SB, SB, SB, SB}));
    chk("idle_ocupado", 64'(ocupado), 64'd0);

    foreach (big_tbl[i]) run_vec(1'b0, big_tbl[i], 0);

    t = '{4321, 1'b0, {S4, S3, S2, S1}, "b4321_ignored_load"};
    run_vec(1'b0, t, 5);

    // Abort a conversion mid-way with reset
    @(negedge clk);
    drive(1'b0, 1'b1, 1234, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 0, 1'b0);
    repeat (7) @(negedge clk);
    chk("abort_busy_before", 64'(ocupado), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_hex_blank", 64'(hex), 64'({SB, SB, SB, SB}));
    chk("abort_ocupado", 64'(ocupado), 64'd0);
    chk("abort_pronto", 64'(pronto), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    npr = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (pronto) npr++;
    end
    chk("abort_no_pronto", 64'(npr), 64'd0);
    chk("abort_hex_after", 64'(hex), 64'({SB, SB, SB, SB}));

    foreach (small_tbl[i]) run_vec(1'b1, small_tbl[i], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
